// File: rtl/wishbone_uart_fifo_if.sv
`default_nettype none
// ============================================================================
// Module : wishbone_uart_fifo_if
// Wishbone classic bus bundle between a bus master and the FIFO-buffered UART.
// Rev    : 1.0
// ============================================================================
interface wishbone_uart_fifo_if;
    logic [31:0] wishbone_addr_i;
    logic [31:0] wishbone_data_i;
    logic        wishbone_we_i;
    logic [3:0]  wishbone_sel_i;
    logic        wishbone_stb_i;
    logic        wishbone_cyc_i;
    logic [31:0] wishbone_data_o;
    logic        wishbone_ack_o;

    modport master (
        output wishbone_addr_i, wishbone_data_i, wishbone_we_i, wishbone_sel_i,
               wishbone_stb_i, wishbone_cyc_i,
        input  wishbone_data_o, wishbone_ack_o
    );

    modport slave (
        input  wishbone_addr_i, wishbone_data_i, wishbone_we_i, wishbone_sel_i,
               wishbone_stb_i, wishbone_cyc_i,
        output wishbone_data_o, wishbone_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wishbone_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module : wishbone_uart_fifo
// Wishbone-mapped 8N1 UART with TX/RX FIFOs, sticky status and level irq.
// Rev    : 1.0
// ============================================================================
module wishbone_uart_fifo #(
    parameter int CLK_FREQ  = 20000000,
    parameter int BAUD_RATE = 115200,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    wishbone_uart_fifo_if.slave  wb,
    output logic                 ser_tx,
    input  logic                 ser_rx,
    output logic                 irq
);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam logic [TX_AW:0]       TX_CNT_FULL = (TX_AW+1)'(TX_DEPTH);
    localparam logic [RX_AW:0]       RX_CNT_FULL = (RX_AW+1)'(RX_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_RST     = DIV_WIDTH'(CLK_FREQ / BAUD_RATE);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_MIN     = DIV_WIDTH'(4);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

    logic                 ack_q, ack_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
    logic                 rx_overrun_q, rx_overrun_d, frame_err_q, frame_err_d;
    logic                 tx_drop_q, tx_drop_d;

    logic [7:0]           tx_mem [TX_DEPTH];
    logic [TX_AW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [TX_AW:0]       tx_count_q, tx_count_d;
    logic [7:0]           rx_mem [RX_DEPTH];
    logic [RX_AW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [RX_AW:0]       rx_count_q, rx_count_d;

    uart_state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]           tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic                 ser_tx_q, ser_tx_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;

    logic       req, bus_wr, bus_rd, data_wr;
    logic [1:0] reg_sel;
    logic       tx_empty, tx_full, rx_empty, rx_full, tx_busy;
    logic       tx_push, tx_pop, rx_push, rx_pop;
    logic       rx_stop_ok, rx_stop_bad;
    logic       unused_bits;

    // A held strobe is ignored while ack is high, giving one access per two cycles.
    assign req      = wb.wishbone_cyc_i & wb.wishbone_stb_i & ~ack_q;
    assign reg_sel  = wb.wishbone_addr_i[3:2];
    assign bus_wr   = req & wb.wishbone_we_i;
    assign bus_rd   = req & ~wb.wishbone_we_i;
    assign data_wr  = bus_wr & (reg_sel == 2'd0);

    assign tx_empty = (tx_count_q == '0);
    assign tx_full  = (tx_count_q == TX_CNT_FULL);
    assign rx_empty = (rx_count_q == '0);
    assign rx_full  = (rx_count_q == RX_CNT_FULL);
    assign tx_busy  = (tx_state_q != ST_IDLE);

    assign tx_push  = data_wr & (~tx_full | tx_pop);
    assign rx_pop   = bus_rd & (reg_sel == 2'd0) & ~rx_empty;
    assign rx_push  = rx_stop_ok & (~rx_full | rx_pop);

    assign wb.wishbone_ack_o  = ack_q;
    assign wb.wishbone_data_o = rdata_q;
    assign ser_tx = ser_tx_q;
    assign irq    = (rx_irq_en_q & ~rx_empty) | (tx_irq_en_q & tx_empty & ~tx_busy);
    assign unused_bits = ^{wb.wishbone_sel_i, wb.wishbone_addr_i, wb.wishbone_data_i};

    always_comb begin
        ack_d        = req;
        rdata_d      = '0;
        div_d        = div_q;
        rx_irq_en_d  = rx_irq_en_q;
        tx_irq_en_d  = tx_irq_en_q;
        rx_overrun_d = rx_overrun_q;
        frame_err_d  = frame_err_q;
        tx_drop_d    = tx_drop_q;
        if (bus_rd) begin
            case (reg_sel)
                2'd0:    rdata_d = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rptr_q]};
                2'd1:    rdata_d = {25'd0, tx_drop_q, frame_err_q, rx_overrun_q,
                                    tx_busy, tx_empty, tx_full, ~rx_empty};
                2'd2:    rdata_d = 32'(div_q);
                default: rdata_d = {30'd0, tx_irq_en_q, rx_irq_en_q};
            endcase
        end
        if (bus_wr && reg_sel == 2'd2) begin
            div_d = (wb.wishbone_data_i[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN
                                                                 : wb.wishbone_data_i[DIV_WIDTH-1:0];
        end
        if (bus_wr && reg_sel == 2'd3) begin
            rx_irq_en_d = wb.wishbone_data_i[0];
            tx_irq_en_d = wb.wishbone_data_i[1];
            if (wb.wishbone_data_i[2]) begin
                rx_overrun_d = 1'b0;
                frame_err_d  = 1'b0;
                tx_drop_d    = 1'b0;
            end
        end
        // New error events win over a same-cycle clear so none is lost.
        if (data_wr && !tx_push)                 tx_drop_d    = 1'b1;
        if (rx_stop_bad)                         frame_err_d  = 1'b1;
        if (rx_stop_ok && rx_full && !rx_pop)    rx_overrun_d = 1'b1;
    end

    always_comb begin
        tx_wptr_d  = tx_wptr_q + TX_AW'(tx_push);
        tx_rptr_d  = tx_rptr_q + TX_AW'(tx_pop);
        tx_count_d = tx_count_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
        rx_wptr_d  = rx_wptr_q + RX_AW'(rx_push);
        rx_rptr_d  = rx_rptr_q + RX_AW'(rx_pop);
        rx_count_d = rx_count_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
    end

    // Bit counters are reloaded from DIV at each bit start, so DIV changes land on bit boundaries.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q - DIV_ONE;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        ser_tx_d   = ser_tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = tx_cnt_q;
                ser_tx_d = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = ST_START;
                    tx_shift_d = tx_mem[tx_rptr_q];
                    tx_cnt_d   = div_q - DIV_ONE;
                    ser_tx_d   = 1'b0;
                end
            end
            ST_START: if (tx_cnt_q == '0) begin
                tx_state_d = ST_DATA;
                tx_bit_d   = 3'd0;
                tx_cnt_d   = div_q - DIV_ONE;
                ser_tx_d   = tx_shift_q[0];
            end
            ST_DATA: if (tx_cnt_q == '0) begin
                tx_cnt_d = div_q - DIV_ONE;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = ST_STOP;
                    ser_tx_d   = 1'b1;
                end else begin
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    ser_tx_d   = tx_shift_q[1];
                end
            end
            default: if (tx_cnt_q == '0) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = ST_START;
                    tx_shift_d = tx_mem[tx_rptr_q];
                    tx_cnt_d   = div_q - DIV_ONE;
                    ser_tx_d   = 1'b0;
                end else begin
                    tx_state_d = ST_IDLE;
                    ser_tx_d   = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q - DIV_ONE;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_stop_ok  = 1'b0;
        rx_stop_bad = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = rx_cnt_q;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = (div_q >> 1) - DIV_ONE;
                end
            end
            ST_START: if (rx_cnt_q == '0) begin
                if (rx_sync_q) begin
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_state_d = ST_DATA;
                    rx_bit_d   = 3'd0;
                    rx_cnt_d   = div_q - DIV_ONE;
                end
            end
            ST_DATA: if (rx_cnt_q == '0) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_cnt_d   = div_q - DIV_ONE;
                if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end
            default: if (rx_cnt_q == '0) begin
                rx_state_d  = ST_IDLE;
                rx_stop_ok  = rx_sync_q;
                rx_stop_bad = ~rx_sync_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr_q] <= wb.wishbone_data_i[7:0];
        if (rx_push) rx_mem[rx_wptr_q] <= rx_shift_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            div_q        <= DIV_RST;
            rx_irq_en_q  <= 1'b0;
            tx_irq_en_q  <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_drop_q    <= 1'b0;
            tx_wptr_q    <= '0;
            tx_rptr_q    <= '0;
            tx_count_q   <= '0;
            rx_wptr_q    <= '0;
            rx_rptr_q    <= '0;
            rx_count_q   <= '0;
            tx_state_q   <= ST_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            ser_tx_q     <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
        end else begin
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            div_q        <= div_d;
            rx_irq_en_q  <= rx_irq_en_d;
            tx_irq_en_q  <= tx_irq_en_d;
            rx_overrun_q <= rx_overrun_d;
            frame_err_q  <= frame_err_d;
            tx_drop_q    <= tx_drop_d;
            tx_wptr_q    <= tx_wptr_d;
            tx_rptr_q    <= tx_rptr_d;
            tx_count_q   <= tx_count_d;
            rx_wptr_q    <= rx_wptr_d;
            rx_rptr_q    <= rx_rptr_d;
            rx_count_q   <= rx_count_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            ser_tx_q     <= ser_tx_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_meta_q    <= ser_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wishbone_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module : tb_wishbone_uart_fifo
// Randomised scoreboard bench for wishbone_uart_fifo against a queue-based UART model.
// Rev    : 1.0
// ============================================================================
module tb_wishbone_uart_fifo;
    localparam int TX_DEPTH = 16;
    localparam int RX_DEPTH = 16;
    localparam int DIV_RST  = 20000000 / 115200;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic ser_tx, irq;
    logic ser_rx = 1'b1;

    wishbone_uart_fifo_if wb();

    wishbone_uart_fifo #(
        .CLK_FREQ(20000000), .BAUD_RATE(115200),
        .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .DIV_WIDTH(16)
    ) dut (
        .clk(clk), .resetn(resetn), .wb(wb),
        .ser_tx(ser_tx), .ser_rx(ser_rx), .irq(irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model of the UART's architectural state.
    int         div_model = DIV_RST;
    logic [7:0] rx_m[$];
    logic [7:0] tx_exp_q[$];
    logic       overrun_m = 1'b0, frame_err_m = 1'b0, tx_drop_m = 1'b0;
    logic [1:0] ctrl_m = 2'b00;
    logic       tx_mon_en = 1'b1;

    logic [32:0] bus_exp_q[$];
    string       bus_name_q[$];
    logic        ack_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status_idle_model();
        return {25'd0, tx_drop_m, frame_err_m, overrun_m, 1'b0, 1'b1, 1'b0, (rx_m.size() != 0)};
    endfunction

    task automatic wb_access(input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                             input logic chk, input logic [31:0] exp, input string name);
        int waited;
        bus_exp_q.push_back({chk, exp});
        bus_name_q.push_back(name);
        @(posedge clk); #1;
        wb.wishbone_cyc_i  = 1'b1;
        wb.wishbone_stb_i  = 1'b1;
        wb.wishbone_we_i   = we;
        wb.wishbone_addr_i = {28'd0, idx, 2'b00};
        wb.wishbone_data_i = wdata;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!wb.wishbone_ack_o && waited < 4);
        check({name, "_ack_latency"}, 32'(waited), 32'd1);
        if (!wb.wishbone_ack_o) begin
            void'(bus_exp_q.pop_back());
            void'(bus_name_q.pop_back());
        end
        wb.wishbone_cyc_i = 1'b0;
        wb.wishbone_stb_i = 1'b0;
        wb.wishbone_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] d);
        wb_access(1'b1, idx, d, 1'b0, 32'd0, "write");
    endtask

    task automatic rd(input logic [1:0] idx, input logic [31:0] exp, input string name);
        wb_access(1'b0, idx, 32'd0, 1'b1, exp, name);
    endtask

    task automatic rd_data();
        logic [31:0] e;
        e = (rx_m.size() != 0) ? {24'd0, rx_m.pop_front()} : 32'd0;
        rd(2'd0, e, "data_read");
    endtask

    task automatic set_div(input int d);
        wr(2'd2, 32'(d));
        div_model = (d < 4) ? 4 : d;
    endtask

    task automatic clear_sticky();
        wr(2'd3, {29'd0, 1'b1, ctrl_m});
        overrun_m = 1'b0; frame_err_m = 1'b0; tx_drop_m = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1;
        ser_rx = 1'b0;
        repeat (div_model) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 ser_rx = b[i];
            repeat (div_model) @(posedge clk);
        end
        #1 ser_rx = stop_bit;
        repeat (div_model) @(posedge clk);
        #1 ser_rx = 1'b1;
        repeat (div_model) @(posedge clk);
        if (!stop_bit)                    frame_err_m = 1'b1;
        else if (rx_m.size() < RX_DEPTH)  rx_m.push_back(b);
        else                              overrun_m = 1'b1;
    endtask

    task automatic wait_tx_drain(input int budget);
        int n = 0;
        while (tx_exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("tx_drain", 32'(tx_exp_q.size()), 32'd0);
        repeat (div_model + 4) @(posedge clk);
    endtask

    // Bus monitor: every ack retires one scoreboard entry.
    always @(negedge clk) begin
        logic [32:0] e;
        string       n;
        if (wb.wishbone_ack_o) begin
            if (ack_prev) begin
                tests++; fails++;
                $display("FAIL ack_width: ack high 2 cycles, required 1");
            end
            if (bus_exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL ack_unexpected: got ack, expected none");
            end else begin
                e = bus_exp_q.pop_front();
                n = bus_name_q.pop_front();
                if (e[32]) check(n, wb.wishbone_data_o, e[31:0]);
            end
        end else if (ack_prev) begin
            check("data_o_idle", wb.wishbone_data_o, 32'd0);
        end
        ack_prev = wb.wishbone_ack_o;
    end

    // Serial monitor: decodes 8N1 frames on ser_tx and retires expected TX bytes.
    initial begin : tx_monitor
        logic [7:0] b, e;
        logic st, sp;
        forever begin
            @(negedge clk);
            if (tx_mon_en && resetn && ser_tx === 1'b0) begin
                repeat (div_model / 2) @(negedge clk);
                st = ser_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (div_model) @(negedge clk);
                    b[i] = ser_tx;
                end
                repeat (div_model) @(negedge clk);
                sp = ser_tx;
                if (tx_mon_en) begin
                    if (tx_exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL tx_unexpected: got frame 0x%0h, expected none", b);
                    end else begin
                        e = tx_exp_q.pop_front();
                        check("tx_frame", {22'd0, st, sp, b}, {22'd0, 1'b0, 1'b1, e});
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        wb.wishbone_cyc_i  = 1'b0;
        wb.wishbone_stb_i  = 1'b0;
        wb.wishbone_we_i   = 1'b0;
        wb.wishbone_addr_i = '0;
        wb.wishbone_data_i = '0;
        wb.wishbone_sel_i  = 4'hF;

        repeat (4) @(posedge clk);
        #1;
        check("rst_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ack", 32'(wb.wishbone_ack_o), 32'd0);
        check("rst_data_o", wb.wishbone_data_o, 32'd0);
        resetn = 1'b1;
        rd(2'd1, 32'h04, "rst_status");
        rd(2'd2, 32'(DIV_RST), "rst_div");
        rd(2'd3, 32'd0, "rst_ctrl");

        set_div(2);
        rd(2'd2, 32'd4, "div_min_clamp");
        set_div(8);
        rd(2'd2, 32'd8, "div_8");

        tx_exp_q.push_back(8'h55);
        wr(2'd0, 32'h55);
        wait_tx_drain(300);
        rd(2'd1, status_idle_model(), "status_after_tx55");

        ctrl_m = 2'b01;
        wr(2'd3, 32'h1);
        send_frame(8'hA3, 1'b1);
        @(negedge clk);
        check("irq_rx", 32'(irq), 32'd1);
        rd(2'd1, status_idle_model(), "status_rx_ready");
        rd_data();
        rd(2'd1, status_idle_model(), "status_rx_drained");
        @(negedge clk);
        check("irq_rx_clear", 32'(irq), 32'd0);

        send_frame(8'h3C, 1'b0);
        rd(2'd1, status_idle_model(), "status_frame_err");
        clear_sticky();
        rd(2'd1, status_idle_model(), "status_cleared");
        rd(2'd3, {30'd0, ctrl_m}, "ctrl_readback");

        @(posedge clk); #1 ser_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 ser_rx = 1'b1;
        repeat (40) @(posedge clk);
        rd(2'd1, status_idle_model(), "status_glitch");

        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 0) set_div($urandom_range(12, 6));
            v = 8'($urandom);
            send_frame(v, ($urandom_range(7, 0) != 0));
            if ($urandom_range(1, 0) != 0) rd_data();
        end
        rd(2'd1, status_idle_model(), "status_rand_rx");
        while (rx_m.size() != 0) rd_data();
        rd_data();
        clear_sticky();

        set_div(8);
        for (int k = 0; k < RX_DEPTH + 1; k++) send_frame(8'(k * 7 + 1), 1'b1);
        rd(2'd1, status_idle_model(), "status_overrun");
        for (int k = 0; k < RX_DEPTH + 1; k++) rd_data();
        clear_sticky();
        rd(2'd1, status_idle_model(), "status_overrun_cleared");

        for (int k = 1; k <= TX_DEPTH + 2; k++) begin
            v = 8'($urandom);
            if (k <= TX_DEPTH + 1) tx_exp_q.push_back(v);
            else                   tx_drop_m = 1'b1;
            wr(2'd0, {24'd0, v});
        end
        rd(2'd1, {25'd0, tx_drop_m, 6'b001010}, "status_tx_burst");
        wait_tx_drain(3000);
        rd(2'd1, status_idle_model(), "status_tx_drop");
        clear_sticky();

        for (int k = 0; k < 3; k++) begin
            set_div($urandom_range(11, 5));
            for (int j = 0; j < 4; j++) begin
                v = 8'($urandom);
                tx_exp_q.push_back(v);
                wr(2'd0, {24'd0, v});
            end
            wait_tx_drain(1000);
        end

        set_div(8);
        ctrl_m = 2'b10;
        wr(2'd3, 32'h2);
        @(negedge clk);
        check("irq_tx_empty", 32'(irq), 32'd1);

        tx_mon_en = 1'b0;
        wr(2'd0, 32'hF0);
        repeat (3) @(posedge clk);
        #1;
        check("tx_start_bit", 32'(ser_tx), 32'd0);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_tx_ser_tx", 32'(ser_tx), 32'd1);
        check("rst_mid_tx_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        rx_m.delete(); tx_exp_q.delete();
        overrun_m = 1'b0; frame_err_m = 1'b0; tx_drop_m = 1'b0; ctrl_m = 2'b00;
        div_model = DIV_RST;
        rd(2'd2, 32'(DIV_RST), "rst_mid_tx_div");
        rd(2'd1, 32'h04, "rst_mid_tx_status");

        repeat (5) @(posedge clk);
        check("bus_scoreboard_empty", 32'(bus_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
